// File: rtl/updown_mod_cntr.sv
// Loadable up/down counter over the range [0, lim] with wrap or saturate at the ends.
// It also produces terminal-count pulses and a sticky range-error flag.
module updown_mod_cntr #(
  parameter int unsigned      WIDTH    = 16,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] lim,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             zero,
  output logic             at_lim,
  output logic             tc_dn,
  output logic             tc_up,
  output logic             err
);

  function automatic logic [WIDTH-1:0] range_up(input logic [WIDTH-1:0] cnt,
                                                input logic [WIDTH-1:0] top);
    if (cnt < top) return cnt + 1'b1;
    return SATURATE ? cnt : '0;
  endfunction

  // A count loaded above lim still steps down normally.
  function automatic logic [WIDTH-1:0] range_dn(input logic [WIDTH-1:0] cnt,
                                                input logic [WIDTH-1:0] top);
    if (cnt != '0) return cnt - 1'b1;
    return SATURATE ? '0 : top;
  endfunction

  logic [WIDTH-1:0] cnt_nxt;
  logic             up_nxt;
  logic             dn_nxt;
  logic             err_set;

  always_comb begin
    cnt_nxt = dout;
    up_nxt  = 1'b0;
    dn_nxt  = 1'b0;
    err_set = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (ld) begin
      cnt_nxt = din;
    end else if (inc && !dec) begin
      cnt_nxt = range_up(dout, lim);
      err_set = (dout >= lim);
      up_nxt  = (dout < lim) && (cnt_nxt == lim);
    end else if (dec && !inc) begin
      cnt_nxt = range_dn(dout, lim);
      err_set = (dout == '0);
      dn_nxt  = (dout != '0) && (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= RST_VAL;
      tc_up <= 1'b0;
      tc_dn <= 1'b0;
      err   <= 1'b0;
    end else begin
      dout  <= cnt_nxt;
      tc_up <= up_nxt;
      tc_dn <= dn_nxt;
      err   <= err_set | (err & ~err_clr);
    end
  end

  assign zero   = (dout == '0);
  assign at_lim = (dout >= lim);

endmodule

// File: tb/tb_updown_mod_cntr.sv
// Directed, table-driven bench for updown_mod_cntr.
// It covers three configurations: 8-bit wrap, 8-bit saturate and 16-bit wrap.
module tb_updown_mod_cntr;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       clr_v, ld_v, inc_v, dec_v, eclr_v;
  logic [2:0][15:0] din_v, lim_v;
  logic [7:0]       dout0, dout1;
  logic [15:0]      dout2;
  logic [2:0]       zero_v, atl_v, dn_v, up_v, err_v;

  updown_mod_cntr #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(8'd5)) u_wrap8 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .ld(ld_v[0]), .din(din_v[0][7:0]),
    .inc(inc_v[0]), .dec(dec_v[0]), .lim(lim_v[0][7:0]), .err_clr(eclr_v[0]),
    .dout(dout0), .zero(zero_v[0]), .at_lim(atl_v[0]), .tc_dn(dn_v[0]),
    .tc_up(up_v[0]), .err(err_v[0]));

  updown_mod_cntr #(.WIDTH(8), .SATURATE(1'b1), .RST_VAL(8'd0)) u_sat8 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .ld(ld_v[1]), .din(din_v[1][7:0]),
    .inc(inc_v[1]), .dec(dec_v[1]), .lim(lim_v[1][7:0]), .err_clr(eclr_v[1]),
    .dout(dout1), .zero(zero_v[1]), .at_lim(atl_v[1]), .tc_dn(dn_v[1]),
    .tc_up(up_v[1]), .err(err_v[1]));

  updown_mod_cntr #(.WIDTH(16), .SATURATE(1'b0), .RST_VAL(16'd0)) u_wrap16 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .ld(ld_v[2]), .din(din_v[2]),
    .inc(inc_v[2]), .dec(dec_v[2]), .lim(lim_v[2]), .err_clr(eclr_v[2]),
    .dout(dout2), .zero(zero_v[2]), .at_lim(atl_v[2]), .tc_dn(dn_v[2]),
    .tc_up(up_v[2]), .err(err_v[2]));

  typedef struct {
    int          sel;
    logic        clr, ld;
    logic [15:0] din;
    logic        inc, dec;
    logic [15:0] lim;
    logic        eclr;
    logic [15:0] e_dout;
    logic        e_dn, e_up, e_err, e_zero, e_atl;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input int s, input logic c, input logic l, input logic [15:0] d,
                     input logic i, input logic dc, input logic [15:0] lm, input logic ec,
                     input logic [15:0] ed, input logic edn, input logic eup,
                     input logic eer, input logic ez, input logic eal);
    vec_t v;
    v.sel = s; v.clr = c; v.ld = l; v.din = d; v.inc = i; v.dec = dc; v.lim = lm;
    v.eclr = ec; v.e_dout = ed; v.e_dn = edn; v.e_up = eup; v.e_err = eer;
    v.e_zero = ez; v.e_atl = eal;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] dout_of(input int s);
    case (s)
      0:       return {8'h00, dout0};
      1:       return {8'h00, dout1};
      default: return dout2;
    endcase
  endfunction

  task automatic idle_cmds();
    clr_v = '0; ld_v = '0; inc_v = '0; dec_v = '0; eclr_v = '0;
  endtask

  task automatic drive(input vec_t v);
    idle_cmds();
    clr_v[v.sel]  = v.clr;
    ld_v[v.sel]   = v.ld;
    din_v[v.sel]  = v.din;
    inc_v[v.sel]  = v.inc;
    dec_v[v.sel]  = v.dec;
    lim_v[v.sel]  = v.lim;
    eclr_v[v.sel] = v.eclr;
  endtask

  task automatic check_all(input string tag, input int s, input logic [15:0] ed,
                           input logic edn, input logic eup, input logic eer,
                           input logic ez, input logic eal);
    chk({tag, "_dout"}, dout_of(s), ed);
    chk({tag, "_tc_dn"}, {15'd0, dn_v[s]}, {15'd0, edn});
    chk({tag, "_tc_up"}, {15'd0, up_v[s]}, {15'd0, eup});
    chk({tag, "_err"}, {15'd0, err_v[s]}, {15'd0, eer});
    chk({tag, "_zero"}, {15'd0, zero_v[s]}, {15'd0, ez});
    chk({tag, "_at_lim"}, {15'd0, atl_v[s]}, {15'd0, eal});
  endtask

  initial begin
    idle_cmds();
    din_v = '0;
    lim_v = '0;
    lim_v[0] = 16'd9;
    lim_v[1] = 16'd3;
    lim_v[2] = 16'hFFFF;

    // sel, clr, ld, din, inc, dec, lim, eclr | dout, tc_dn, tc_up, err, zero, at_lim
    add(0,0,1,2,0,0,9,0,      2,0,0,0,0,0);
    add(0,0,0,0,0,1,9,0,      1,0,0,0,0,0);
    add(0,0,0,0,0,1,9,0,      0,1,0,0,1,0);
    add(0,0,0,0,0,1,9,0,      9,0,0,1,0,1);
    add(0,0,0,0,0,0,9,0,      9,0,0,1,0,1);
    add(0,0,0,0,0,0,9,1,      9,0,0,0,0,1);
    add(0,1,1,7,1,0,9,0,      0,0,0,0,1,0);
    add(0,0,1,7,0,1,9,0,      7,0,0,0,0,0);
    add(0,0,0,0,1,1,9,0,      7,0,0,0,0,0);
    add(0,0,1,8,0,0,9,0,      8,0,0,0,0,0);
    add(0,0,0,0,1,0,9,0,      9,0,1,0,0,1);
    add(0,0,0,0,1,0,9,0,      0,0,0,1,1,0);
    add(0,0,0,0,0,1,9,1,      9,0,0,1,0,1);
    add(0,1,0,0,0,0,9,0,      0,0,0,1,1,0);
    add(0,0,1,3,0,0,9,0,      3,0,0,1,0,0);
    add(0,0,0,0,0,0,9,1,      3,0,0,0,0,0);
    add(0,0,1,10,0,0,4,0,     10,0,0,0,0,1);
    add(0,0,0,0,1,0,4,0,      0,0,0,1,1,0);
    add(0,0,1,10,0,0,4,1,     10,0,0,0,0,1);
    add(0,0,0,0,0,1,4,0,      9,0,0,0,0,1);
    add(0,1,0,0,0,0,0,0,      0,0,0,0,1,1);
    add(0,0,0,0,1,0,0,0,      0,0,0,1,1,1);
    add(0,0,0,0,0,0,0,1,      0,0,0,0,1,1);
    add(0,0,0,0,0,1,0,0,      0,0,0,1,1,1);
    add(0,0,0,0,0,0,0,1,      0,0,0,0,1,1);
    add(1,1,0,0,0,0,3,0,      0,0,0,0,1,0);
    add(1,0,0,0,1,0,3,0,      1,0,0,0,0,0);
    add(1,0,0,0,1,0,3,0,      2,0,0,0,0,0);
    add(1,0,0,0,1,0,3,0,      3,0,1,0,0,1);
    add(1,0,0,0,1,0,3,0,      3,0,0,1,0,1);
    add(1,0,0,0,1,0,3,0,      3,0,0,1,0,1);
    add(1,0,0,0,0,1,3,1,      2,0,0,0,0,0);
    add(1,0,0,0,0,1,3,0,      1,0,0,0,0,0);
    add(1,0,0,0,0,1,3,0,      0,1,0,0,1,0);
    add(1,0,0,0,0,1,3,0,      0,0,0,1,1,0);
    add(1,0,0,0,1,0,1,1,      1,0,1,0,0,1);
    add(2,0,1,16'hFFFF,0,0,16'hFFFF,0, 16'hFFFF,0,0,0,0,1);
    add(2,0,0,0,1,0,16'hFFFF,0,        16'h0000,0,0,1,1,0);
    add(2,0,0,0,0,1,16'hFFFF,0,        16'hFFFF,0,0,1,0,1);

    // Power-on reset, asynchronous
    #2 rst_n = 1'b0;
    #1;
    chk("por_dout_w8", dout_of(0), 16'd5);
    chk("por_dout_s8", dout_of(1), 16'd0);
    chk("por_dout_w16", dout_of(2), 16'd0);
    chk("por_flags", {13'd0, err_v | dn_v | up_v}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].sel, tbl[i].e_dout, tbl[i].e_dn,
                tbl[i].e_up, tbl[i].e_err, tbl[i].e_zero, tbl[i].e_atl);
    end

    // Mid-count reset with err and tc_dn high
    idle_cmds(); lim_v[0] = 16'd9;
    ld_v[0] = 1'b1; din_v[0] = 16'd0;
    @(posedge clk); #1;
    ld_v[0] = 1'b0; dec_v[0] = 1'b1;
    @(posedge clk); #1;
    dec_v[0] = 1'b0; ld_v[0] = 1'b1; din_v[0] = 16'd1;
    @(posedge clk); #1;
    ld_v[0] = 1'b0; dec_v[0] = 1'b1;
    @(posedge clk); #1;
    check_all("pre_rst", 0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dec_v[0] = 1'b0; inc_v[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_dout", dout_of(0), 16'd5);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_inc", dout_of(0), 16'd6);
    idle_cmds();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_mod_cntr.md
# updown_mod_cntr

Parametrised loadable up/down modulo counter for datapath loop control. It is the successor to the fixed 16-bit load/decrement counter and adds:
- an increment direction;
- a programmable limit (modulus) with selectable wrap or saturate behaviour;
- a synchronous clear;
- terminal-count pulses and a sticky range-error flag.

Controllers use it for iteration counts, shift counts and address stepping.

## Interface
Parameters:
- WIDTH, 16, counter and data width in bits (≥2)
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends
- RST_VAL, 0, value of dout after reset (WIDTH bits)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of dout to 0
- ld  input  1  synchronous load of din into dout
- din  input  WIDTH  load value
- inc  input  1  count up by 1
- dec  input  1  count down by 1
- lim  input  WIDTH  upper bound of the counting range [0, lim]; sampled every cycle
- err_clr  input  1  clears the sticky err flag
- dout  output  WIDTH  current count (register)
- zero  output  1  combinational: dout == 0
- at_lim  output  1  combinational: dout >= lim
- tc_dn  output  1  registered one-cycle pulse: dout became 0 through a dec step
- tc_up  output  1  registered one-cycle pulse: dout became lim through an inc step
- err  output  1  sticky: an inc or dec was attempted at a range end

## Operation
- Priority per cycle: clr > ld > (inc XOR dec) > hold.
- inc and dec asserted together, with no clr or ld, holds the count: no pulse, no err.
- clr: dout ← 0; tc_dn = 0 and tc_up = 0 in the same cycle.
- ld: dout ← din exactly, even when din > lim. No pulse, no err.
- inc, when dout < lim: dout ← dout + 1. tc_up = 1 if the new value equals lim.
- inc, when dout >= lim:
  - wrap mode: dout ← 0, err set.
  - saturate mode: dout unchanged, err set.
  - No tc_up in either mode.
- dec, when dout > 0: dout ← dout − 1. tc_dn = 1 if the new value is 0.
- dec, when dout == 0:
  - wrap mode: dout ← lim, err set.
  - saturate mode: dout holds 0, err set.
  - No tc_dn in either mode.
- dec, when dout > lim (only reachable after a load): decrements normally; not an error.
- Arithmetic is unsigned modulo 2^WIDTH. With lim = 2^WIDTH−1 in wrap mode, the block behaves as a plain binary counter, with err flagging each wrap.
- lim = 0: the count is pinned at 0.
  - Every inc or dec sets err.
  - In wrap mode the count stays 0, because lim is 0.
- err:
  - Set by the conditions above.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - clr and ld do not affect err.
- tc_dn and tc_up are pulses: high for exactly the one cycle after the step edge. They are never both high.

## Timing
- Reset (rst_n low, asynchronous, independent of clk): dout = RST_VAL, tc_dn = 0, tc_up = 0, err = 0. These hold while rst_n is low.
- Reset deassertion is synchronised externally. The first active edge is the first rising clk edge with rst_n high.
- Reset asserted mid-count discards the count; nothing is retained.
- Latency is 1 cycle: a command sampled at edge N is visible on dout, tc_* and err after edge N.
- zero and at_lim follow dout (and lim) combinationally, with no added latency.
- Back-to-back commands are accepted every cycle; there is no handshake and no busy state.
- A lim change takes effect for the command sampled on the same edge.

## Test plan
- Reset: drive rst_n low mid-count with RST_VAL = 5 → dout = 5, err = 0 and tc_* = 0 immediately, without waiting for clk.
- Down wrap (WIDTH = 8, SATURATE = 0, lim = 9):
  - ld din = 2, then dec ×3 → dout 1, 0, 9.
  - tc_dn pulses exactly once, after the step to 0.
  - err is set on the third dec and stays set until err_clr.
- Up saturate (SATURATE = 1, lim = 3):
  - clr, then inc ×5 → dout 1, 2, 3, 3, 3.
  - tc_up is a single pulse on reaching 3.
  - err is set on the 4th inc.
- Priority: in one cycle assert clr, ld (din = 7) and inc → dout = 0. Then ld = 7 with dec → dout = 7. Then inc and dec together → dout stays 7, no pulses.
- Over-limit load (lim = 4): ld din = 10 → dout = 10 and at_lim = 1. inc → wrap mode gives 0 with err set. Reload 10, then dec → 9 with no err.
- Full-range wrap (WIDTH = 16, lim = 16'hFFFF): ld 16'hFFFF, then inc → dout = 0, err set. dec → 16'hFFFF, zero = 0.
